// File: rtl/apb_slave_mem_if.sv
// APB3 completer bus bundle: requester drives select/enable/write/address/data,
// completer returns read data, ready and error.
interface apb_slave_mem_if #(
  parameter int ADDR_W = 16
);
  logic              psel_i;
  logic              penable_i;
  logic              pwrite_i;
  logic [ADDR_W-1:0] paddr_i;
  logic [31:0]       pwdata_i;
  logic [31:0]       prdata_o;
  logic              pready_o;
  logic              pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB3 completer with a word-addressed SRAM and WAIT_CYCLES programmable wait states.
// Optional APB_SLV_ERR_EN: out-of-range word index returns pslverr; otherwise index wraps.
module apb_slave_mem #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  apb_slave_mem_if.slave   bus
);
  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [31:0]         prdata_q, prdata_d;
  logic                lat_wr_q, lat_wr_d;
  logic                lat_err_q, lat_err_d;
  logic [MEM_AW-1:0]   lat_idx_q, lat_idx_d;
  logic [31:0]         lat_wdata_q, lat_wdata_d;
  logic                mem_we;
  logic                in_err;
  logic                setup;

  logic [31:0]         mem [DEPTH];

  logic [IDX_W-1:0]    in_idx;
  assign in_idx = bus.paddr_i[ADDR_W-1:2];
  assign setup  = bus.psel_i & ~bus.penable_i;

`ifdef APB_SLV_ERR_EN
  // Extra top bit keeps the compare exact when DEPTH == 2**IDX_W.
  assign in_err = {1'b0, in_idx} >= (IDX_W+1)'(DEPTH);
`else
  assign in_err = 1'b0;
`endif

  wire unused_ok = ^{bus.paddr_i[1:0], in_idx};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pready_d    = pready_q;
    pslverr_d   = pslverr_q;
    prdata_d    = prdata_q;
    lat_wr_d    = lat_wr_q;
    lat_err_d   = lat_err_q;
    lat_idx_d   = lat_idx_q;
    lat_wdata_d = lat_wdata_q;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        if (setup) begin
          state_d     = ACCESS;
          cnt_d       = WAIT_INIT;
          lat_wr_d    = bus.pwrite_i;
          lat_err_d   = in_err;
          lat_idx_d   = in_idx[MEM_AW-1:0];
          lat_wdata_d = bus.pwdata_i;
          // Zero-wait: the access cycle itself is the completion, so read data
          // must come from the setup-phase address on this edge.
          if (ZERO_WAIT) begin
            pready_d  = 1'b1;
            pslverr_d = in_err;
            if (!bus.pwrite_i) prdata_d = in_err ? 32'h0 : mem[in_idx[MEM_AW-1:0]];
          end
        end
      end
      ACCESS: begin
        if (!bus.psel_i) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (pready_q) begin
          if (bus.penable_i) begin
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            if (lat_wr_q) begin
              mem_we   = ~lat_err_q;
              prdata_d = 32'h0;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = lat_err_q;
            if (!lat_wr_q) prdata_d = lat_err_q ? 32'h0 : mem[lat_idx_q];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      lat_wr_q    <= 1'b0;
      lat_err_q   <= 1'b0;
      lat_idx_q   <= '0;
      lat_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      lat_wr_q    <= lat_wr_d;
      lat_err_q   <= lat_err_d;
      lat_idx_q   <= lat_idx_d;
      lat_wdata_q <= lat_wdata_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[lat_idx_q] <= lat_wdata_q;
  end

  assign bus.prdata_o  = prdata_q;
  assign bus.pready_o  = pready_q;
  assign bus.pslverr_o = pslverr_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (2, 0 and 3 wait states) driven from one
// APB requester, checked against an array-based memory model.
module tb_apb_slave_mem;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  int          sel;
  logic [31:0] prdata;
  logic        pready, pslverr;
  int          n_pass, n_total;

  always #5 clk = ~clk;

  apb_slave_mem_if #(.ADDR_W(16)) if0 ();
  apb_slave_mem_if #(.ADDR_W(16)) if1 ();
  apb_slave_mem_if #(.ADDR_W(16)) if2 ();

  assign if0.psel_i = psel & (sel == 0);
  assign if1.psel_i = psel & (sel == 1);
  assign if2.psel_i = psel & (sel == 2);
  assign if0.penable_i = penable & (sel == 0);
  assign if1.penable_i = penable & (sel == 1);
  assign if2.penable_i = penable & (sel == 2);
  assign {if0.pwrite_i, if0.paddr_i, if0.pwdata_i} = {pwrite, paddr, pwdata};
  assign {if1.pwrite_i, if1.paddr_i, if1.pwdata_i} = {pwrite, paddr, pwdata};
  assign {if2.pwrite_i, if2.paddr_i, if2.pwdata_i} = {pwrite, paddr, pwdata};

  apb_slave_mem #(.ADDR_W(16), .DEPTH(64), .WAIT_CYCLES(2)) dut_w2 (.clk(clk), .reset_n(reset_n), .bus(if0));
  apb_slave_mem #(.ADDR_W(16), .DEPTH(64), .WAIT_CYCLES(0)) dut_w0 (.clk(clk), .reset_n(reset_n), .bus(if1));
  apb_slave_mem #(.ADDR_W(16), .DEPTH(64), .WAIT_CYCLES(3)) dut_w3 (.clk(clk), .reset_n(reset_n), .bus(if2));

  always_comb begin
    case (sel)
      0:       {prdata, pready, pslverr} = {if0.prdata_o, if0.pready_o, if0.pslverr_o};
      1:       {prdata, pready, pslverr} = {if1.prdata_o, if1.pready_o, if1.pslverr_o};
      default: {prdata, pready, pslverr} = {if2.prdata_o, if2.pready_o, if2.pslverr_o};
    endcase
  end

  // Reference model: one word array per instance plus a written-yet flag.
  logic [31:0] ref_mem [3][64];
  bit          ref_vld [3][64];
  int          ref_wait [3] = '{2, 0, 3};

  function automatic bit exp_err(input logic [15:0] a);
`ifdef APB_SLV_ERR_EN
    return int'(a[15:2]) >= 64;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int midx(input logic [15:0] a);
    return int'(a[15:2]) % 64;
  endfunction

  task automatic mdl_write(input int s, input logic [15:0] a, input logic [31:0] d);
    if (!exp_err(a)) begin
      ref_mem[s][midx(a)] = d;
      ref_vld[s][midx(a)] = 1'b1;
    end
  endtask

  // One complete transfer starting at a negedge; returns at the negedge after completion.
  // Address/data/direction are scrambled during ACCESS to prove setup values are latched.
  task automatic xfer(input bit wr, input logic [15:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int waits, output logic err,
                      output logic post_rdy, output logic [31:0] post_rd);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    pwrite = 1'($urandom_range(0, 1)); paddr = 16'($urandom); pwdata = $urandom;
    waits = 0;
    while (!pready && waits < 40) begin
      @(negedge clk);
      waits++;
      paddr = 16'($urandom); pwdata = $urandom;
    end
    rd = prdata; err = pslverr;
    @(negedge clk);
    post_rdy = pready; post_rd = prdata;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd, prd; int w; logic e, prdy;
    reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; sel = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      n_total++;
      if ({prdata, pready, pslverr} !== 34'h0) $display("FAIL reset_state dut%0d: got %h/%b/%b want 0/0/0", s, prdata, pready, pslverr);
      else n_pass++;
    end
    sel = 0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    xfer(1'b1, 16'h0020, 32'h1111_2222, rd, w, e, prdy, prd); mdl_write(0, 16'h0020, 32'h1111_2222);
    xfer(1'b0, 16'h0020, 32'h0, rd, w, e, prdy, prd);
    n_total++;
    if (rd !== 32'h1111_2222) $display("FAIL reset_prewrite: got %h want 11112222", rd); else n_pass++;
    // Start a write, then reset it mid-ACCESS.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0020; pwdata = 32'h3333_4444;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); #2 reset_n = 1'b0; #1;
    n_total++;
    if ({prdata, pready, pslverr} !== 34'h0) $display("FAIL reset_async: got %h/%b/%b want 0/0/0", prdata, pready, pslverr);
    else n_pass++;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({prdata, pready, pslverr} !== 34'h0) $display("FAIL reset_release: got %h/%b/%b want 0/0/0", prdata, pready, pslverr);
    else n_pass++;
    xfer(1'b0, 16'h0020, 32'h0, rd, w, e, prdy, prd);
    n_total++;
    if (rd !== ref_mem[0][8] || w !== 2) $display("FAIL reset_first_setup: got data %h waits %0d want %h waits 2", rd, w, ref_mem[0][8]);
    else n_pass++;
  endtask

  task automatic test_wait2();
    logic [31:0] rd, prd; int w; logic e, prdy;
    sel = 0;
    xfer(1'b1, 16'h0010, 32'hDEAD_BEEF, rd, w, e, prdy, prd); mdl_write(0, 16'h0010, 32'hDEAD_BEEF);
    n_total++;
    if (w !== 2 || e !== 1'b0) $display("FAIL wait2_write: got waits %0d err %b want 2 0", w, e); else n_pass++;
    n_total++;
    if (prdy !== 1'b0 || prd !== 32'h0) $display("FAIL wait2_write_after: got rdy %b data %h want 0 0", prdy, prd); else n_pass++;
    @(negedge clk);
    xfer(1'b0, 16'h0010, 32'h0, rd, w, e, prdy, prd);
    n_total++;
    if (w !== 2 || rd !== 32'hDEAD_BEEF) $display("FAIL wait2_read: got waits %0d data %h want 2 deadbeef", w, rd); else n_pass++;
    n_total++;
    if (prdy !== 1'b0 || prd !== 32'hDEAD_BEEF) $display("FAIL wait2_read_hold: got rdy %b data %h want 0 deadbeef", prdy, prd); else n_pass++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd, prd; int w; logic e, prdy;
    logic [15:0] addrs [4] = '{16'h0000, 16'h0004, 16'h0000, 16'h0004};
    sel = 1;
    for (int i = 0; i < 4; i++) begin
      xfer(i < 2, addrs[i], 32'(i + 1), rd, w, e, prdy, prd);
      if (i < 2) mdl_write(1, addrs[i], 32'(i + 1));
      n_total++;
      if (w !== 0 || prdy !== 1'b0) $display("FAIL zero_wait_timing[%0d]: got waits %0d post_rdy %b want 0 0", i, w, prdy); else n_pass++;
      if (i >= 2) begin
        n_total++;
        if (rd !== ref_mem[1][midx(addrs[i])]) $display("FAIL zero_wait_read[%0d]: got %h want %h", i, rd, ref_mem[1][midx(addrs[i])]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd, prd; int w; logic e, prdy; int seen;
    sel = 0;
    xfer(1'b1, 16'h0008, 32'h0, rd, w, e, prdy, prd); mdl_write(0, 16'h0008, 32'h0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0008; pwdata = 32'hAAAA_5555;
    seen = 0;
    @(negedge clk); penable = 1'b1; seen += int'(pready);
    @(negedge clk); seen += int'(pready);
    psel = 1'b0; penable = 1'b0;
    repeat (4) begin @(negedge clk); seen += int'(pready); end
    n_total++;
    if (seen !== 0) $display("FAIL abort_no_ready: got %0d ready cycles want 0", seen); else n_pass++;
    xfer(1'b0, 16'h0008, 32'h0, rd, w, e, prdy, prd);
    n_total++;
    if (rd !== ref_mem[0][2]) $display("FAIL abort_no_write: got %h want %h", rd, ref_mem[0][2]); else n_pass++;
  endtask

  task automatic test_penable_idle();
    logic [31:0] rd, prd; int w; logic e, prdy; int seen;
    sel = 0; seen = 0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 16'h0010;
    repeat (4) begin @(negedge clk); seen += int'(pready); end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    n_total++;
    if (seen !== 0) $display("FAIL penable_idle: got %0d ready cycles want 0", seen); else n_pass++;
    xfer(1'b0, 16'h0010, 32'h0, rd, w, e, prdy, prd);
    n_total++;
    if (rd !== 32'hDEAD_BEEF || w !== 2) $display("FAIL penable_idle_recover: got %h waits %0d want deadbeef 2", rd, w); else n_pass++;
  endtask

  task automatic test_range();
    logic [31:0] rd, prd; int w; logic e, prdy;
    sel = 0;
    xfer(1'b1, 16'h0000, 32'hCAFE_0000, rd, w, e, prdy, prd); mdl_write(0, 16'h0000, 32'hCAFE_0000);
    xfer(1'b1, 16'h0100, 32'h1234_5678, rd, w, e, prdy, prd); mdl_write(0, 16'h0100, 32'h1234_5678);
    n_total++;
    if (e !== exp_err(16'h0100) || w !== 2) $display("FAIL range_write_resp: got err %b waits %0d want %b 2", e, w, exp_err(16'h0100));
    else n_pass++;
    xfer(1'b0, 16'h0000, 32'h0, rd, w, e, prdy, prd);
    n_total++;
    if (rd !== ref_mem[0][0] || e !== 1'b0) $display("FAIL range_read0: got %h err %b want %h 0", rd, e, ref_mem[0][0]);
    else n_pass++;
    xfer(1'b0, 16'h0104, 32'h0, rd, w, e, prdy, prd);
    n_total++;
    if (e !== exp_err(16'h0104) || (e === 1'b1 && rd !== 32'h0)) $display("FAIL range_read_oob: got err %b data %h want err %b", e, rd, exp_err(16'h0104));
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd, prd, d; int w; logic e, prdy; bit wr; logic [15:0] a; int bad;
    sel = 2; bad = 0;
    for (int i = 0; i < 512; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 16'($urandom_range(0, 127) * 4 + $urandom_range(0, 3));
      d  = $urandom;
      xfer(wr, a, d, rd, w, e, prdy, prd);
      n_total++;
      if (w !== ref_wait[2] || e !== exp_err(a) || prdy !== 1'b0) begin
        $display("FAIL rand_resp[%0d] a=%h: got waits %0d err %b post_rdy %b want %0d %b 0", i, a, w, e, prdy, ref_wait[2], exp_err(a));
        bad++;
      end else n_pass++;
      if (wr) mdl_write(2, a, d);
      else if (exp_err(a) || ref_vld[2][midx(a)]) begin
        n_total++;
        if (rd !== (exp_err(a) ? 32'h0 : ref_mem[2][midx(a)])) begin
          $display("FAIL rand_read[%0d] a=%h: got %h want %h", i, a, rd, exp_err(a) ? 32'h0 : ref_mem[2][midx(a)]);
          bad++;
        end else n_pass++;
      end
      if (bad > 10) break;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    for (int s = 0; s < 3; s++) for (int j = 0; j < 64; j++) begin ref_mem[s][j] = '0; ref_vld[s][j] = 1'b0; end
    test_reset();
    test_wait2();
    test_zero_wait();
    test_abort();
    test_penable_idle();
    test_range();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end
endmodule
